// File: rtl/tc_program_port_arbiter_if.sv
// tc_program_port_arbiter_if: requester, response and ROM-side signals of the program port arbiter
interface tc_program_port_arbiter_if #(parameter int ADDR_W = 16);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              flush0;
  logic              rsp0_valid;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              flush1;
  logic              rsp1_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_in0, mem_in1, mem_in2, mem_in3;
  modport master (
    output req0_valid, req0_addr, flush0, req1_valid, req1_addr, flush1,
           mem_in0, mem_in1, mem_in2, mem_in3,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_data, rsp_err, mem_addr
  );
  modport slave (
    input  req0_valid, req0_addr, flush0, req1_valid, req1_addr, flush1,
           mem_in0, mem_in1, mem_in2, mem_in3,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_data, rsp_err, mem_addr
  );
endinterface

// File: rtl/tc_program_port_arbiter.sv
// tc_program_port_arbiter: round-robin sharing of a registered 32-bit ROM read port between fetch and load ports.
// Define TC_PROG_ARB_FIXED_PRI_EN to give port 0 fixed priority instead of round-robin.
module tc_program_port_arbiter #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 16
) (
  input logic clk,
  input logic rst,
  tc_program_port_arbiter_if.slave bus
);
  localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);
  logic              w_e0, w_e1, w_g0, w_g1, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic              r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_s1_v, r_s1_p, r_s1_e;
  logic              r_s2_v, r_s2_p, r_s2_e;
  always_comb begin
    w_e0 = bus.req0_valid & ~bus.flush0;
    w_e1 = bus.req1_valid & ~bus.flush1;
`ifdef TC_PROG_ARB_FIXED_PRI_EN
    w_g1 = w_e1 & ~w_e0;
`else
    w_g1 = w_e1 & (~w_e0 | ~r_last);
`endif
    w_g0 = w_e0 & ~w_g1;
    w_addr = w_g1 ? bus.req1_addr : bus.req0_addr;
    w_err = 32'(w_addr) > LAST_OK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_mem_addr <= '0;
      r_s1_v     <= 1'b0;
      r_s1_p     <= 1'b0;
      r_s1_e     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s2_p     <= 1'b0;
      r_s2_e     <= 1'b0;
    end else begin
      if (w_g0 | w_g1) begin
        r_mem_addr <= w_addr;
        r_last     <= w_g1;
      end
      r_s1_v <= w_g0 | w_g1;
      r_s1_p <= w_g1;
      r_s1_e <= w_err;
      // a new stage-1 entry never belongs to a flushed port, so only the advancing entry needs masking
      r_s2_v <= r_s1_v & ~(r_s1_p ? bus.flush1 : bus.flush0);
      r_s2_p <= r_s1_p;
      r_s2_e <= r_s1_e;
    end
  end
  assign bus.req0_ready = w_g0;
  assign bus.req1_ready = w_g1;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.rsp0_valid = r_s2_v & ~r_s2_p & ~bus.flush0;
  assign bus.rsp1_valid = r_s2_v & r_s2_p & ~bus.flush1;
  assign bus.rsp_err    = r_s2_v & r_s2_e;
  assign bus.rsp_data   = bus.rsp_err ? 32'h0 : {bus.mem_in3, bus.mem_in2, bus.mem_in1, bus.mem_in0};
endmodule

// File: tb/tb_tc_program_port_arbiter.sv
// tb_tc_program_port_arbiter: randomized scoreboard bench with a ROM model and a transaction-level arbiter model
module tb_tc_program_port_arbiter;
  localparam int MEM = 256;
  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  logic [7:0] rom [MEM];
  item_t exp_q[$];
  logic [1:0] exp_rdy = 2'b00;
  logic [15:0] exp_maddr = 16'h0;
  int last_grant = 1;
  tc_program_port_arbiter_if #(.ADDR_W(16)) bus();
  tc_program_port_arbiter #(.MEM_BYTES(MEM), .ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] rb(int a);
    return (a < MEM) ? rom[a] : 8'hEE;
  endfunction
  always @(posedge clk) begin
    bus.mem_in0 <= rb(int'(bus.mem_addr));
    bus.mem_in1 <= rb(int'(bus.mem_addr) + 1);
    bus.mem_in2 <= rb(int'(bus.mem_addr) + 2);
    bus.mem_in3 <= rb(int'(bus.mem_addr) + 3);
  end
  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, got, exp);
    end
  endfunction
  always @(negedge clk) begin
    item_t it;
    logic [1:0] got_v;
    got_v = {bus.rsp1_valid, bus.rsp0_valid};
    chk("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
    chk("mem_addr", bus.mem_addr, exp_maddr);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      it = exp_q.pop_front();
      chk("rsp_valid", got_v, (it.port == 1) ? 2'b10 : 2'b01);
      chk("rsp_err", bus.rsp_err, it.err);
      chk("rsp_data", bus.rsp_data, it.data);
    end else
      chk("rsp_idle", got_v, 2'b00);
  end
  // One cycle of stimulus; the model decides the winner and schedules the response two cycles later.
  task automatic step(input logic v0, input logic [15:0] a0, input logic f0,
                      input logic v1, input logic [15:0] a1, input logic f1);
    item_t it, keep[$];
    bit e0, e1;
    int g, a;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.flush0 = f0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.flush1 = f1;
    foreach (exp_q[i]) if (!((exp_q[i].port == 0 && f0) || (exp_q[i].port == 1 && f1))) keep.push_back(exp_q[i]);
    exp_q = keep;
    e0 = v0 && !f0;
    e1 = v1 && !f1;
`ifdef TC_PROG_ARB_FIXED_PRI_EN
    g = e0 ? 0 : (e1 ? 1 : -1);
`else
    g = (e0 && e1) ? 1 - last_grant : (e0 ? 0 : (e1 ? 1 : -1));
`endif
    exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    a = (g == 1) ? int'(a1) : int'(a0);
    if (g >= 0) begin
      last_grant = g;
      it.port = g;
      it.err = (a + 3 > MEM - 1);
      it.data = it.err ? 32'h0 : {rom[a+3], rom[a+2], rom[a+1], rom[a]};
      it.due = cyc + 2;
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
    if (g >= 0) exp_maddr = 16'(a);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 16'h0, 0, 0, 16'h0, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.flush0 = 0; bus.flush1 = 0;
    exp_q.delete();
    exp_rdy = 2'b00;
    exp_maddr = 16'h0;
    last_grant = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  function automatic logic [15:0] raddr();
    case ($urandom % 8)
      0: return 16'hFFF0 + 16'($urandom % 16);
      1: return 16'(MEM - 8 + $urandom % 8);
      default: return 16'($urandom % MEM);
    endcase
  endfunction
  initial begin
    foreach (rom[i]) rom[i] = 8'($urandom);
    rom[16] = 8'h11; rom[17] = 8'h22; rom[18] = 8'h33; rom[19] = 8'h44;
    bus.req0_valid = 0; bus.req0_addr = 0; bus.flush0 = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.flush1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 16'h0010, 0, 0, 16'h0, 0);
    idle(3);
    repeat (8) step(1, 16'h0000, 0, 1, 16'h0040, 0);
    idle(3);
    step(1, 16'h0020, 0, 0, 16'h0, 0);
    step(0, 16'h0, 1, 1, 16'h0030, 0);
    idle(4);
    step(0, 16'h0, 0, 1, 16'h00FD, 0);
    step(0, 16'h0, 0, 1, 16'h00FC, 0);
    step(0, 16'h0, 0, 1, 16'hFFFE, 0);
    idle(3);
    step(1, 16'h0004, 0, 1, 16'h0008, 0);
    step(1, 16'h0004, 0, 1, 16'h0008, 0);
    do_reset();
    idle(3);
    repeat (4) step(1, 16'h0004, 0, 1, 16'h0008, 0);
    step(0, 16'h0004, 0, 1, 16'h0008, 0);
    step(1, 16'h0010, 1, 1, 16'h0014, 1);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom % 4 != 0, raddr(), $urandom % 8 == 0,
           $urandom % 4 != 0, raddr(), $urandom % 8 == 0);
    end
    idle(4);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tc_program_port_arbiter.md
Name: tc_program_port_arbiter

Overview:
- Shares one registered 4-byte-wide program ROM read port between two requesters: port 0 is instruction fetch, port 1 is the data/constant load path.
- Sits between the requesters and the ROM. It drives the ROM address and tags each issued read with its port.
- Returns the 32-bit word to the owning port two cycles after acceptance.
- Round-robin arbitration, one accepted read per cycle, per-port flush for branch redirect, and an out-of-range error flag.

Parameters:
- MEM_BYTES, 256, ROM size in bytes. A read is in range iff addr + 3 <= MEM_BYTES - 1.
- ADDR_W, 16, width of the request and ROM address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  ADDR_W  port 0 byte address.
- req0_ready  out  1  port 0 accepted this cycle (combinational).
- flush0  in  1  drop port 0 in-flight reads and block port 0 acceptance this cycle.
- rsp0_valid  out  1  response for port 0 on rsp_data/rsp_err.
- req1_valid, req1_addr, req1_ready, flush1, rsp1_valid  —  same as port 0, for port 1.
- rsp_data  out  32  {mem_in3, mem_in2, mem_in1, mem_in0}; forced to 0 when rsp_err=1.
- rsp_err  out  1  current response address was out of range.
- mem_addr  out  ADDR_W  registered ROM address.
- mem_in0..mem_in3  in  8 each  ROM byte outputs. The ROM registers them at posedge, one cycle after mem_addr.

Behaviour:
- Reset values, asynchronous:
  - mem_addr = 0.
  - Both pipeline stages invalid, so rsp0_valid = rsp1_valid = 0 and rsp_err = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Eligibility: port N is eligible when reqN_valid = 1 and flushN = 0.
- Grant, combinational:
  - Only one port eligible: that port wins.
  - Both eligible: the port != last_grant wins.
  - Asserting ready never depends on the previous response.
  - reqN_ready = 1 only for the winner. At most one ready per cycle.
- Acceptance at edge k (the winner's valid and ready both high):
  - mem_addr <= winner's addr.
  - Stage 1 <= {valid = 1, port, err = (addr > MEM_BYTES - 4)}.
  - last_grant <= winner.
- No acceptance at edge k: stage 1 valid <= 0, and mem_addr holds its value.
- Edge k+1: stage 2 <= stage 1. The ROM latches its data at the same edge.
- Cycle k+2:
  - rspP_valid = stage2.valid & (stage2.port == P) & ~flushP.
  - rsp_err = stage2.err & stage2.valid.
- Latency: 2 cycles from accept to response.
- Throughput: 1 read per cycle. Up to 2 reads in flight.
- No response backpressure: consumers must take the response in the cycle it is valid.
- Flush of port P at an edge:
  - Clears the valid bit of every stage entry tagged P, in stage 1 and stage 2.
  - The flush also combinationally masks rspP_valid in the same cycle.
  - Entries tagged for the other port are unaffected.
  - Port P cannot be accepted in that cycle. The other port may be accepted, and it wins without comparing last_grant.
- Both flushes high: no acceptance, and all in-flight entries are dropped.
- Address arithmetic is unsigned in ADDR_W bits. An addr near 2^ADDR_W - 1 is out of range (no wrap), so err = 1.
- Reset mid-operation: in-flight responses are lost and never appear after reset deasserts.

Optional Feature:
- Macro: TC_PROG_ARB_FIXED_PRI_EN.
- Defined:
  - Fixed priority: port 0 always wins contention, and last_grant is unused.
  - Port 1 is granted only when port 0 is ineligible.
- Undefined: the round-robin rule above.

Test Plan:
- Reset, then req0 addr 0x0010 alone, with ROM bytes 0x10..0x13 = 11 22 33 44 -> req0_ready=1 in cycle 0; mem_addr=0x0010 after edge 0; rsp0_valid=1, rsp_data=0x44332211, rsp_err=0 in cycle 2; rsp1_valid stays 0.
- Both ports valid continuously, port 0 addr 0x00, port 1 addr 0x40 -> grants alternate 0,1,0,1 from the first cycle; responses alternate rsp0/rsp1 every cycle with 2-cycle latency and correct data.
- Port 0 accepted at edge k, then flush0 high in cycle k+1 with port 1 valid -> port 1 accepted in cycle k+1; rsp0_valid never asserts for the flushed read; port 1 response arrives at k+3.
- req1 addr 0x00FD with MEM_BYTES=256 -> rsp1_valid=1, rsp_err=1, rsp_data=0 at cycle 2. Addr 0x00FC -> rsp_err=0.
- Assert rst in cycle k+1 with two reads in flight -> all valids drop immediately, and no response appears after release; first contention after release grants port 0.
- With TC_PROG_ARB_FIXED_PRI_EN defined, both ports valid for 4 cycles -> port 0 is granted every cycle, and port 1 is granted in the first cycle req0_valid=0.
